t08_regfile_sequencer: RTL and testbench

// - Initiator side of the t08_registers port set. Accepts one decoded instruction at a time
//   (rs1/rs2/rd/write-back source), drives RF read enables/addresses, captures operands for execute.
// - Waits for the result (ALU, link value, or memory load handshake), then issues one RF write strobe.
// - Sits between decode and t08_registers. One instruction in flight; issue_ready low while busy.

---
 rtl/t08_regfile_sequencer_pkg.sv | 27 ++
 rtl/t08_regfile_sequencer_wait_counter.sv | 35 +++
 rtl/t08_regfile_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_t08_regfile_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t08_regfile_sequencer_pkg.sv
// t08_pkg: shared types for the register-file sequencer.
//   wb_src_t : write-back source select, same encoding as the register file's
//              rf_data_in_control input (0 memory, 1 link, 2 ALU, 3 none).
//   state_t  : sequencer FSM states, also exported on the debug state port.
package t08_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    WB_MEM  = 2'd0,
    WB_IF   = 2'd1,
    WB_ALU  = 2'd2,
    WB_NONE = 2'd3
  } wb_src_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_EXEC     = 3'd3,
    ST_WAIT_ALU = 3'd4,
    ST_WAIT_MEM = 3'd5,
    ST_WRITE    = 3'd6
  } state_t;

endpackage

// File: rtl/t08_regfile_sequencer_wait_counter.sv
// t08_wait_counter: cycle counter used to bound the wait for load data.
// Ports:
//   clk, nRst : clock, asynchronous active-low reset
//   clear     : synchronous clear (wins over enable)
//   enable    : count one cycle
//   expire    : combinational, high while the count equals TIMEOUT-1,
//               i.e. during the TIMEOUT-th enabled cycle after a clear
module t08_wait_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  // One spare bit so the terminal value TIMEOUT-1 always fits.
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/t08_regfile_sequencer.sv
// t08_regfile_sequencer: initiator side of the t08_registers port set.
// Takes one decoded instruction at a time, reads its source registers,
// presents the operands to execute for one cycle, waits for the result
// (ALU, link value or load data) and issues a single register-file write.
//
// Handshake: an instruction transfers on a rising edge where issue_valid and
// issue_ready are both high; issue_ready is high only in IDLE, so exactly one
// instruction is in flight. ex_valid / mem_valid are single-cycle result
// strobes that are only looked at in WAIT_ALU / WAIT_MEM respectively.
//
// Ports:
//   clk, nRst                 clock, asynchronous active-low reset
//   issue_*                   instruction from decode (rs1/rs2/use flags, rd,
//                             write-back source, link value)
//   op_valid, op_a, op_b      captured operands, valid for one cycle in EXEC
//   ex_valid, ex_result       ALU result strobe
//   mem_valid, mem_data       load data strobe
//   mem_timeout_err           one-cycle pulse after a load wait times out
//   rf_*                      register-file read/write controls and data
//   dbg_state                 current FSM state
module t08_regfile_sequencer
  import t08_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        issue_use_rs1,
  input  logic        issue_use_rs2,
  input  logic [4:0]  issue_rd,
  input  logic [1:0]  issue_wb_src,
  input  logic [31:0] issue_link,
  output logic        op_valid,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  output logic        mem_timeout_err,
  output logic [4:0]  rf_address_r1,
  output logic [4:0]  rf_address_r2,
  output logic [4:0]  rf_address_rd,
  output logic        rf_en_read_1,
  output logic        rf_en_read_2,
  output logic        rf_en_write,
  output logic [1:0]  rf_data_in_control,
  output logic [31:0] rf_data_in_frommemory,
  output logic [31:0] rf_data_in_frominstructionfetch,
  output logic [31:0] rf_data_in_fromalu,
  input  logic [31:0] rf_data_out_r1,
  input  logic [31:0] rf_data_out_r2,
  output state_t      dbg_state
);

  state_t  state, state_next;

  // Fields latched at issue.
  logic [4:0] rs1_q, rs2_q, rd_q;
  logic       use_rs1_q, use_rs2_q;
  wb_src_t    wb_q;

  logic accept;
  logic latch_alu, latch_mem;
  logic err_set;
  logic cnt_clear, cnt_en, cnt_expire;

  // A write-back only happens for a non-zero destination; waits still run
  // to completion so the result handshake is consumed either way.
  logic has_rd;
  assign has_rd = (rd_q != 5'd0);

  t08_wait_counter #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_wait_counter (
    .clk    (clk),
    .nRst   (nRst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .expire (cnt_expire)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    latch_alu  = 1'b0;
    latch_mem  = 1'b0;
    err_set    = 1'b0;
    cnt_clear  = 1'b1;   // counter held at zero outside WAIT_MEM
    cnt_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (issue_valid) begin
          accept     = 1'b1;
          state_next = ST_READ;
        end
      end
      ST_READ:    state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_EXEC;
      ST_EXEC: begin
        case (wb_q)
          WB_ALU:  state_next = ST_WAIT_ALU;
          WB_MEM:  state_next = ST_WAIT_MEM;
          WB_IF:   state_next = has_rd ? ST_WRITE : ST_IDLE;
          default: state_next = ST_IDLE;
        endcase
      end
      ST_WAIT_ALU: begin
        if (ex_valid) begin
          latch_alu  = 1'b1;
          state_next = has_rd ? ST_WRITE : ST_IDLE;
        end
      end
      ST_WAIT_MEM: begin
        cnt_clear = 1'b0;
        cnt_en    = 1'b1;
        // Data arriving on the last counted cycle still wins over the timeout.
        if (mem_valid) begin
          latch_mem  = 1'b1;
          state_next = has_rd ? ST_WRITE : ST_IDLE;
        end else if (cnt_expire) begin
          err_set    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WRITE:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Issue fields and link value.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rs1_q                           <= '0;
      rs2_q                           <= '0;
      rd_q                            <= '0;
      use_rs1_q                       <= 1'b0;
      use_rs2_q                       <= 1'b0;
      wb_q                            <= WB_MEM;
      rf_data_in_frominstructionfetch <= '0;
    end else if (accept) begin
      rs1_q                           <= issue_rs1;
      rs2_q                           <= issue_rs2;
      rd_q                            <= issue_rd;
      use_rs1_q                       <= issue_use_rs1;
      use_rs2_q                       <= issue_use_rs2;
      wb_q                            <= wb_src_t'(issue_wb_src);
      rf_data_in_frominstructionfetch <= issue_link;
    end
  end

  // Operand capture: RF read data is valid the cycle after the enable.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      op_a <= '0;
      op_b <= '0;
    end else if (state == ST_CAPTURE) begin
      op_a <= use_rs1_q ? rf_data_out_r1 : 32'd0;
      op_b <= use_rs2_q ? rf_data_out_r2 : 32'd0;
    end
  end

  // Result registers and timeout pulse.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rf_data_in_fromalu    <= '0;
      rf_data_in_frommemory <= '0;
      mem_timeout_err       <= 1'b0;
    end else begin
      if (latch_alu) rf_data_in_fromalu    <= ex_result;
      if (latch_mem) rf_data_in_frommemory <= mem_data;
      mem_timeout_err <= err_set;
    end
  end

  assign issue_ready        = (state == ST_IDLE);
  assign op_valid           = (state == ST_EXEC);
  assign rf_en_read_1       = (state == ST_READ) && use_rs1_q;
  assign rf_en_read_2       = (state == ST_READ) && use_rs2_q;
  assign rf_en_write        = (state == ST_WRITE);
  assign rf_address_r1      = rs1_q;
  assign rf_address_r2      = rs2_q;
  assign rf_address_rd      = rd_q;
  assign rf_data_in_control = wb_q;
  assign dbg_state          = state;

endmodule

// File: tb/tb_t08_regfile_sequencer.sv
// Bench for t08_regfile_sequencer, paired with a behavioural register file
// (registered reads one edge after enable, x0 hardwired to zero, cleared by
// reset). Expected operands and writes are queued at issue time and popped
// by a monitor on the falling edge.
module tb_t08_regfile_sequencer;
  import t08_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
  logic        issue_use_rs1 = 1'b0, issue_use_rs2 = 1'b0;
  logic [1:0]  issue_wb_src = 2'd3;
  logic [31:0] issue_link = '0;
  logic        op_valid;
  logic [31:0] op_a, op_b;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_result = '0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic        mem_timeout_err;
  logic [4:0]  rf_address_r1, rf_address_r2, rf_address_rd;
  logic        rf_en_read_1, rf_en_read_2, rf_en_write;
  logic [1:0]  rf_data_in_control;
  logic [31:0] rf_data_in_frommemory, rf_data_in_frominstructionfetch, rf_data_in_fromalu;
  logic [31:0] rf_data_out_r1, rf_data_out_r2;
  state_t      dbg_state;

  t08_regfile_sequencer #(.MEM_TIMEOUT(16)) dut (
    .clk                             (clk),
    .nRst                            (nRst),
    .issue_valid                     (issue_valid),
    .issue_ready                     (issue_ready),
    .issue_rs1                       (issue_rs1),
    .issue_rs2                       (issue_rs2),
    .issue_use_rs1                   (issue_use_rs1),
    .issue_use_rs2                   (issue_use_rs2),
    .issue_rd                        (issue_rd),
    .issue_wb_src                    (issue_wb_src),
    .issue_link                      (issue_link),
    .op_valid                        (op_valid),
    .op_a                            (op_a),
    .op_b                            (op_b),
    .ex_valid                        (ex_valid),
    .ex_result                       (ex_result),
    .mem_valid                       (mem_valid),
    .mem_data                        (mem_data),
    .mem_timeout_err                 (mem_timeout_err),
    .rf_address_r1                   (rf_address_r1),
    .rf_address_r2                   (rf_address_r2),
    .rf_address_rd                   (rf_address_rd),
    .rf_en_read_1                    (rf_en_read_1),
    .rf_en_read_2                    (rf_en_read_2),
    .rf_en_write                     (rf_en_write),
    .rf_data_in_control              (rf_data_in_control),
    .rf_data_in_frommemory           (rf_data_in_frommemory),
    .rf_data_in_frominstructionfetch (rf_data_in_frominstructionfetch),
    .rf_data_in_fromalu              (rf_data_in_fromalu),
    .rf_data_out_r1                  (rf_data_out_r1),
    .rf_data_out_r2                  (rf_data_out_r2),
    .dbg_state                       (dbg_state)
  );

  // ---------------- behavioural register file ----------------
  logic [31:0] regs [32];
  logic [31:0] rf_wdata;

  always_comb begin
    rf_wdata = 32'd0;
    case (rf_data_in_control)
      2'd0:    rf_wdata = rf_data_in_frommemory;
      2'd1:    rf_wdata = rf_data_in_frominstructionfetch;
      2'd2:    rf_wdata = rf_data_in_fromalu;
      default: rf_wdata = 32'd0;
    endcase
  end

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      rf_data_out_r1 <= 32'd0;
      rf_data_out_r2 <= 32'd0;
    end else begin
      if (rf_en_read_1) rf_data_out_r1 <= regs[rf_address_r1];
      if (rf_en_read_2) rf_data_out_r2 <= regs[rf_address_r2];
      if (rf_en_write && rf_address_rd != 5'd0) regs[rf_address_rd] <= rf_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  logic [63:0] exp_op_q [$];   // {op_a, op_b}
  logic [38:0] exp_wr_q [$];   // {rd, control, data}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic op_valid_d = 1'b0;
  logic en_write_d = 1'b0;

  always @(negedge clk) begin
    if (nRst) begin
      if (op_valid) begin
        check("op_valid_width", {63'd0, op_valid_d}, 64'd0);
        if (exp_op_q.size() == 0) begin
          check("op_unexpected", {63'd0, op_valid}, 64'd0);
        end else begin
          logic [63:0] e;
          e = exp_op_q.pop_front();
          check("op_a", {32'd0, op_a}, {32'd0, e[63:32]});
          check("op_b", {32'd0, op_b}, {32'd0, e[31:0]});
        end
      end
      if (rf_en_write) begin
        check("wr_width", {63'd0, en_write_d}, 64'd0);
        check("wr_rd_overlap", {63'd0, rf_en_read_1 | rf_en_read_2}, 64'd0);
        if (exp_wr_q.size() == 0) begin
          check("wr_unexpected", {63'd0, rf_en_write}, 64'd0);
        end else begin
          logic [38:0] w;
          w = exp_wr_q.pop_front();
          check("wr_rd", {59'd0, rf_address_rd}, {59'd0, w[38:34]});
          check("wr_ctl", {62'd0, rf_data_in_control}, {62'd0, w[33:32]});
          check("wr_data", {32'd0, rf_wdata}, {32'd0, w[31:0]});
        end
      end
      if (mem_timeout_err) err_seen++;
    end
    op_valid_d = op_valid && nRst;
    en_write_d = rf_en_write && nRst;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic [1:0] src, input logic [31:0] link);
    @(negedge clk);
    check("issue_ready_before", {63'd0, issue_ready}, 64'd1);
    issue_rs1 = rs1; issue_rs2 = rs2; issue_use_rs1 = u1; issue_use_rs2 = u2;
    issue_rd = rd; issue_wb_src = src; issue_link = link; issue_valid = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!issue_ready && cyc < max);
    check(tag, {63'd0, issue_ready}, 64'd1);
  endtask

  task automatic wait_state(input string tag, input state_t s, input int max);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (dbg_state != s && c < max);
    check(tag, {61'd0, dbg_state}, {61'd0, s});
  endtask

  task automatic pulse_mem(input logic [31:0] d);
    mem_valid = 1'b1; mem_data = d;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;

    // Reset values
    #2;
    check("rst_ready", {63'd0, issue_ready}, 64'd1);
    check("rst_op_valid", {63'd0, op_valid}, 64'd0);
    check("rst_rf_ctrl", {61'd0, rf_en_read_1, rf_en_read_2, rf_en_write}, 64'd0);
    check("rst_err", {63'd0, mem_timeout_err}, 64'd0);
    check("rst_op_a", {32'd0, op_a}, 64'd0);
    @(negedge clk); @(negedge clk);
    nRst = 1'b1;

    // Link write rd=5 <- 1024, ready returns on the fifth cycle after accept
    exp_op_q.push_back({32'd0, 32'd0});
    exp_wr_q.push_back({5'd5, 2'd1, 32'd1024});
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 2'd1, 32'd1024);
    check("link_at_issue", {32'd0, rf_data_in_frominstructionfetch}, 64'd1024);
    wait_idle("link_idle", 20, cyc);
    check("link_latency", 64'(cyc), 64'd5);

    // Read back rs2=5, no write-back
    exp_op_q.push_back({32'd0, 32'd1024});
    issue(5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 2'd3, 32'd0);
    wait_idle("rd5_idle", 20, cyc);
    check("none_latency", 64'(cyc), 64'd4);

    // Load rd=13 <- 345, data three cycles after WAIT_MEM entry; stray ex_valid ignored
    ex_valid = 1'b1; ex_result = 32'hDEAD;
    exp_op_q.push_back({32'd0, 32'd0});
    exp_wr_q.push_back({5'd13, 2'd0, 32'd345});
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 2'd0, 32'd77);
    wait_state("load_wait", ST_WAIT_MEM, 10);
    repeat (3) @(negedge clk);
    ex_valid = 1'b0;
    pulse_mem(32'd345);
    wait_idle("load_idle", 20, cyc);

    // Dual read rs1=13, rs2=18
    exp_op_q.push_back({32'd345, 32'd0});
    issue(5'd13, 5'd18, 1'b1, 1'b1, 5'd0, 2'd3, 32'd0);
    wait_idle("dual_idle", 20, cyc);

    // Timeout: no mem_valid for 16 cycles
    exp_op_q.push_back({32'd0, 32'd0});
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 2'd0, 32'd0);
    wait_idle("tmo_idle", 40, cyc);
    check("tmo_latency", 64'(cyc), 64'd20);
    check("tmo_err_pulse", {63'd0, mem_timeout_err}, 64'd1);
    @(negedge clk);
    check("tmo_err_clear", {63'd0, mem_timeout_err}, 64'd0);
    check("tmo_err_count", 64'(err_seen), 64'd1);

    // mem_valid on the final count cycle wins
    exp_op_q.push_back({32'd0, 32'd0});
    exp_wr_q.push_back({5'd20, 2'd0, 32'h0000ABCD});
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd20, 2'd0, 32'd0);
    wait_state("last_wait", ST_WAIT_MEM, 10);
    repeat (15) @(negedge clk);
    pulse_mem(32'h0000ABCD);
    wait_idle("last_idle", 20, cyc);
    check("last_no_err", 64'(err_seen), 64'd1);

    // rd=0 ALU: result consumed, no write
    exp_op_q.push_back({32'd0, 32'd0});
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd2, 32'd0);
    wait_state("x0_wait", ST_WAIT_ALU, 10);
    ex_valid = 1'b1; ex_result = 32'd7;
    @(posedge clk); #1; ex_valid = 1'b0;
    wait_idle("x0_idle", 20, cyc);

    // ALU write rd=3 <- 0x55 after a two-cycle wait
    exp_op_q.push_back({32'd0, 32'd0});
    exp_wr_q.push_back({5'd3, 2'd2, 32'h55});
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 2'd2, 32'd0);
    wait_state("alu_wait", ST_WAIT_ALU, 10);
    repeat (2) @(negedge clk);
    ex_valid = 1'b1; ex_result = 32'h55;
    @(posedge clk); #1; ex_valid = 1'b0;
    wait_idle("alu_idle", 20, cyc);

    // Reset while waiting for load data; later mem_valid must not write
    exp_op_q.push_back({32'd0, 32'd0});
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 2'd0, 32'd0);
    wait_state("mrst_wait", ST_WAIT_MEM, 10);
    #3 nRst = 1'b0;
    #1;
    check("mrst_ready", {63'd0, issue_ready}, 64'd1);
    check("mrst_op_valid", {63'd0, op_valid}, 64'd0);
    check("mrst_rf_ctrl", {61'd0, rf_en_read_1, rf_en_read_2, rf_en_write}, 64'd0);
    check("mrst_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    @(negedge clk);
    mem_valid = 1'b1; mem_data = 32'd99;
    @(negedge clk);
    nRst = 1'b1;
    repeat (2) @(negedge clk);
    mem_valid = 1'b0;
    check("mrst_still_idle", {61'd0, dbg_state}, {61'd0, ST_IDLE});

    // reg13 reads 0 after reset
    exp_op_q.push_back({32'd0, 32'd0});
    issue(5'd13, 5'd0, 1'b1, 1'b0, 5'd0, 2'd3, 32'd0);
    wait_idle("r13_idle", 20, cyc);

    repeat (2) @(negedge clk);
    check("op_q_empty", 64'(exp_op_q.size()), 64'd0);
    check("wr_q_empty", 64'(exp_wr_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
